// File: rtl/imm_decode_ctrl.sv
// ID-stage controller: decodes the immediate-select code at accept and buffers two entries in a skid buffer.
// Optional macro IMM_DECODE_ILLEGAL_CNT_EN adds the saturating ILLEGAL_CNT output.
module imm_decode_ctrl #(
   parameter int PC_WIDTH  = 32,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 FLUSH,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [31:0]          INSTR,
   input  logic [PC_WIDTH-1:0]  PC_IN,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [24:0]          SE_IN,
   output logic [2:0]           IMM_SEL,
   output logic [PC_WIDTH-1:0]  OUT_PC,
   output logic                 USES_IMM,
   output logic                 ILLEGAL
`ifdef IMM_DECODE_ILLEGAL_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] ILLEGAL_CNT
`endif
);

   typedef struct packed {
      logic [24:0]         se;
      logic [2:0]          sel;
      logic [PC_WIDTH-1:0] pc;
      logic                uses_imm;
      logic                illegal;
   } entry_t;

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   if (CNT_WIDTH < 1) begin : g_cnt_width_check
      $error("CNT_WIDTH must be at least 1");
   end

   logic [1:0] state;
   entry_t     e0;
   entry_t     e1;
   entry_t     new_entry;
   entry_t     head;
   logic       accept;
   logic       pop;

   always_comb begin
      // NOTE: every field gets a default before the case, so no path can infer a latch.
      new_entry          = '0;
      new_entry.se       = INSTR[31:7];
      new_entry.pc       = PC_IN;
      new_entry.sel      = 3'b110;
      new_entry.illegal  = 1'b0;
      case (INSTR[6:0])
         7'b0110111, 7'b0010111: new_entry.sel = 3'b000;
         7'b1101111:             new_entry.sel = 3'b001;
         7'b0100011:             new_entry.sel = 3'b010;
         7'b1100011:             new_entry.sel = 3'b011;
         7'b0000011, 7'b1100111: new_entry.sel = 3'b100;
         7'b0010011: begin
            case (INSTR[14:12])
               3'b001, 3'b101: new_entry.sel = 3'b101;
               3'b011:         new_entry.sel = 3'b111;
               default:        new_entry.sel = 3'b100;
            endcase
         end
         7'b0110011:             new_entry.sel = 3'b110;
         default:                new_entry.illegal = 1'b1;
      endcase
      new_entry.uses_imm = (new_entry.sel != 3'b110);
   end

   // Ready looks only at registered occupancy and RESET/FLUSH, never at OUT_READY.
   assign IN_READY  = ~RESET & ~FLUSH & (state != S_FULL);
   assign OUT_VALID = (state != S_EMPTY);
   assign accept    = IN_VALID & IN_READY;
   assign pop       = OUT_VALID & OUT_READY;

   // E0 may hold a stale entry after draining, so the head is masked when empty.
   assign head     = OUT_VALID ? e0 : '0;
   assign SE_IN    = head.se;
   assign IMM_SEL  = head.sel;
   assign OUT_PC   = head.pc;
   assign USES_IMM = head.uses_imm;
   assign ILLEGAL  = head.illegal;

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so each flop sees pre-edge values.
      if (RESET) begin
         state <= S_EMPTY;
         // NOTE: the entries are explicitly cleared on reset so no buffered instruction survives it.
         e0    <= '0;
         e1    <= '0;
      end else if (FLUSH) begin
         state <= S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: begin
               if (accept) begin
                  state <= S_ONE;
                  e0    <= new_entry;
               end
            end
            S_ONE: begin
               if (accept && pop) begin
                  e0 <= new_entry;
               end else if (accept) begin
                  state <= S_FULL;
                  e1    <= new_entry;
               end else if (pop) begin
                  state <= S_EMPTY;
               end
            end
            S_FULL: begin
               if (pop) begin
                  state <= S_ONE;
                  e0    <= e1;
               end
            end
            default: state <= S_EMPTY;
         endcase
      end
   end

`ifdef IMM_DECODE_ILLEGAL_CNT_EN
   // A pop coincident with FLUSH still reached ID/EX, so it is counted.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ILLEGAL_CNT <= '0;
      end else if (pop && e0.illegal && (ILLEGAL_CNT != {CNT_WIDTH{1'b1}})) begin
         ILLEGAL_CNT <= ILLEGAL_CNT + CNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Scoreboard bench for imm_decode_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_imm_decode_ctrl;
   localparam int PC_WIDTH  = 32;
   localparam int CNT_WIDTH = 8;

   logic                CLK       = 1'b0;
   logic                RESET     = 1'b1;
   logic                FLUSH     = 1'b0;
   logic                IN_VALID  = 1'b0;
   logic                OUT_READY = 1'b0;
   logic [31:0]         INSTR     = 32'h0;
   logic [PC_WIDTH-1:0] PC_IN     = '0;
   logic                IN_READY;
   logic                OUT_VALID;
   logic [24:0]         SE_IN;
   logic [2:0]          IMM_SEL;
   logic [PC_WIDTH-1:0] OUT_PC;
   logic                USES_IMM;
   logic                ILLEGAL;
`ifdef IMM_DECODE_ILLEGAL_CNT_EN
   logic [CNT_WIDTH-1:0] ILLEGAL_CNT;
   int                   cnt_exp = 0;
`endif

   imm_decode_ctrl #(.PC_WIDTH(PC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .INSTR(INSTR), .PC_IN(PC_IN),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .SE_IN(SE_IN), .IMM_SEL(IMM_SEL),
      .OUT_PC(OUT_PC), .USES_IMM(USES_IMM), .ILLEGAL(ILLEGAL)
`ifdef IMM_DECODE_ILLEGAL_CNT_EN
      , .ILLEGAL_CNT(ILLEGAL_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [24:0]         se;
      logic [2:0]          sel;
      logic [PC_WIDTH-1:0] pc;
      logic                uses;
      logic                ill;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests   = 0;
   int   n_fail    = 0;
   logic ready_exp = 1'b0;

   localparam logic [6:0] OPS [0:9] = '{7'h37, 7'h17, 7'h6F, 7'h23, 7'h63,
                                         7'h03, 7'h67, 7'h13, 7'h13, 7'h33};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode: instruction class by opcode, then the immediate format it needs.
   function automatic exp_t model(input logic [31:0] ins, input logic [PC_WIDTH-1:0] pc);
      exp_t       e;
      logic [6:0] op;
      logic [2:0] f3;
      op    = ins[6:0];
      f3    = ins[14:12];
      e.se  = ins[31:7];
      e.pc  = pc;
      e.ill = 1'b0;
      if (op == 7'h37 || op == 7'h17)      e.sel = 3'd0;
      else if (op == 7'h6F)                e.sel = 3'd1;
      else if (op == 7'h23)                e.sel = 3'd2;
      else if (op == 7'h63)                e.sel = 3'd3;
      else if (op == 7'h03 || op == 7'h67) e.sel = 3'd4;
      else if (op == 7'h13)                e.sel = (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 :
                                                   (f3 == 3'd3) ? 3'd7 : 3'd4;
      else if (op == 7'h33)                e.sel = 3'd6;
      else begin
         e.sel = 3'd6;
         e.ill = 1'b1;
      end
      e.uses = (e.sel != 3'd6);
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 9) != 0) r[6:0] = OPS[$urandom_range(0, 9)];
      return r;
   endfunction

   // Drive one cycle of stimulus; record the expected entry if the model says it is accepted.
   task automatic step(input logic v, input logic [31:0] ins, input logic [PC_WIDTH-1:0] pc,
                       input logic ordy, input logic fl, input logic rst);
      @(posedge CLK);
      #1;
      IN_VALID  = v;
      INSTR     = ins;
      PC_IN     = pc;
      OUT_READY = ordy;
      FLUSH     = fl;
      RESET     = rst;
      @(negedge CLK);
      #1;
      if (v && ready_exp) exp_q.push_back(model(ins, pc));
   endtask

   // Monitor: compares the head against the scoreboard and retires entries on pop/flush/reset.
   initial begin
      exp_t h;
      logic r;
      logic do_pop;
      forever begin
         @(negedge CLK);
         h = '{default: '0};
         if (exp_q.size() != 0) h = exp_q[0];
         r = !RESET && !FLUSH && (exp_q.size() < 2);
         check("out_valid", 64'(OUT_VALID), 64'(exp_q.size() != 0));
         check("in_ready", 64'(IN_READY), 64'(r));
         check("head", {2'b00, SE_IN, IMM_SEL, OUT_PC, USES_IMM, ILLEGAL},
               {2'b00, h.se, h.sel, h.pc, h.uses, h.ill});
         do_pop = (exp_q.size() != 0) && OUT_READY && !RESET;
`ifdef IMM_DECODE_ILLEGAL_CNT_EN
         check("illegal_cnt", 64'(ILLEGAL_CNT), 64'(cnt_exp));
         if (RESET) cnt_exp = 0;
         else if (do_pop && h.ill && cnt_exp < (2 ** CNT_WIDTH) - 1) cnt_exp++;
`endif
         if (RESET || FLUSH) exp_q.delete();
         else if (do_pop) void'(exp_q.pop_front());
         ready_exp = r;
      end
   end

   initial begin
      logic [31:0] stream [0:5];
      stream = '{32'h000012B7, 32'h0080006F, 32'h00112023, 32'h00208463, 32'h00209093, 32'h0000B113};

      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

      // addi x1,x0,5 lands on the outputs one edge after acceptance
      step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("addi_valid", 64'(OUT_VALID), 64'(1'b1));
      check("addi_sel", 64'(IMM_SEL), 64'(3'b100));
      check("addi_se", 64'(SE_IN), 64'(25'h00A001));
      check("addi_pc", 64'(OUT_PC), 64'(32'h100));
      check("addi_uses", 64'(USES_IMM), 64'(1'b1));
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // back-to-back formats with no bubbles
      for (int i = 0; i < 6; i++) step(1'b1, stream[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // stall: only two entries fit, then in-order drain
      for (int i = 0; i < 5; i++) step(1'b1, rand_instr(), 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      check("stall_in_ready", 64'(IN_READY), 64'(1'b0));
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // flush while full; the flushed-cycle instruction is dropped
      step(1'b1, 32'h00500093, 32'h400, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0080006F, 32'h404, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00112023, 32'h408, 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("flush_valid", 64'(OUT_VALID), 64'(1'b0));

      // register-register op and an illegal opcode
      step(1'b1, 32'h00000033, 32'h500, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'hFFFFFFFF, 32'h504, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("illegal_flag", 64'(ILLEGAL), 64'(1'b1));
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // reset while full and stalled
      step(1'b1, rand_instr(), 32'h600, 1'b0, 1'b0, 1'b0);
      step(1'b1, rand_instr(), 32'h604, 1'b0, 1'b0, 1'b0);
      step(1'b1, rand_instr(), 32'h608, 1'b0, 1'b0, 1'b1);
      step(1'b1, rand_instr(), 32'h60C, 1'b0, 1'b0, 1'b1);
      check("rst_valid", 64'(OUT_VALID), 64'(1'b0));
      check("rst_in_ready", 64'(IN_READY), 64'(1'b0));
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("post_rst_in_ready", 64'(IN_READY), 64'(1'b1));

`ifdef IMM_DECODE_ILLEGAL_CNT_EN
      for (int i = 0; i < 300; i++) step(1'b1, 32'hFFFFFFFF, 32'(i), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("illegal_cnt_sat", 64'(ILLEGAL_CNT), 64'({CNT_WIDTH{1'b1}}));
`endif

      // randomized traffic with occasional flush and reset
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom_range(0, 9) < 6,
              $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
